alu_issue_sequencer: RTL and testbench

//  Initiator side of the ALU control interface. Accepts op requests (valid/ready), drives the ALU

---
 rtl/alu_seq_pkg.sv | 53 +++++
 rtl/alu_seq_rsp_fifo.sv | 48 ++++
 rtl/alu_issue_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_issue_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU issue sequencer: opcodes, the per-op control word and its decoder.
package alu_seq_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_SLT = 3'b100
    } op_e;

    typedef struct packed {
        logic [1:0] ctrl;
        logic       sub;
        logic       stl;
        logic       cin;
        logic [1:0] bmux;
        logic       amux;
        logic [1:0] osel;
        logic       illegal;
    } ctrl_word_t;

    // Illegal opcodes fall through with AND controls and the illegal flag set.
    function automatic ctrl_word_t decode_op(input logic [2:0] op, input logic [1:0] asrc,
                                             input logic bsrc, input logic [1:0] osel);
        ctrl_word_t w;
        w      = '0;
        w.bmux = asrc;
        w.amux = bsrc;
        w.osel = osel;
        case (op)
            OP_AND: w.ctrl = 2'b00;
            OP_OR:  w.ctrl = 2'b01;
            OP_ADD: w.ctrl = 2'b10;
            OP_SUB: begin
                w.ctrl = 2'b10;
                w.sub  = 1'b1;
                w.cin  = 1'b1;
            end
            OP_SLT: begin
                w.ctrl = 2'b11;
                w.sub  = 1'b1;
                w.stl  = 1'b1;
                w.cin  = 1'b1;
            end
            default: w.illegal = 1'b1;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/alu_seq_rsp_fifo.sv
// Synchronous response FIFO; payload is an opaque packed word (data, tag, flags) of width W.
module alu_seq_rsp_fifo #(
    parameter int W     = 21,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               push_data_i,
    input  logic                       pop_i,
    output logic                       rd_valid_o,
    output logic [W-1:0]               rd_data_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_pop;

    assign do_pop = pop_i && (count_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_i) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Storage is never cleared, so the head is masked while empty.
    assign rd_valid_o = (count_q != '0);
    assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;

endmodule

// File: rtl/alu_issue_sequencer.sv
// ALU issue sequencer: decoded ops travel a LATENCY-deep shift pipeline whose taps drive the ALU
// controls; results are sampled at the last stage into a credit-limited response FIFO.
// Optional macro ALU_SEQ_ZFLAG_EN captures alu_zero at TAP_ZERO and returns it on rsp_zero.
module alu_issue_sequencer
    import alu_seq_pkg::*;
#(
    parameter int LATENCY    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4,
    parameter int TAP_SEL    = 1,
    parameter int TAP_INV    = 3,
    parameter int TAP_ADD    = 4,
    parameter int TAP_MUX    = 12,
    parameter int TAP_OSEL   = 15,
    parameter int TAP_ZERO   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [1:0]        req_asrc,
    input  logic              req_bsrc,
    input  logic [1:0]        req_osel,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              alu_ctrl0,
    output logic              alu_ctrl1,
    output logic              alu_sub,
    output logic              alu_stl,
    output logic              alu_cin,
    output logic              alu_bmux0,
    output logic              alu_bmux1,
    output logic              alu_amux,
    output logic              alu_mux3_0,
    output logic              alu_mux3_1,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_illegal,
    output logic              busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef ALU_SEQ_ZFLAG_EN
    localparam int PW = DATA_W + TAG_W + 2;
    localparam int ZN = LATENCY - 1 - TAP_ZERO;
`else
    localparam int PW = DATA_W + TAG_W + 1;
`endif

    ctrl_word_t       word_q [LATENCY];
    logic [TAG_W-1:0] tag_q  [LATENCY];
    logic [LATENCY-1:0] vld_q;
    logic [CW-1:0]    inflight_q;
    logic [CW-1:0]    inflight_d;
    logic [CW-1:0]    fifo_count;
    logic             accept;
    logic             retire;
    logic [PW-1:0]    push_data;
    logic [PW-1:0]    rd_data;

    // Credits cover both in-flight ops and buffered responses, so a retire always finds a slot.
    assign req_ready  = (inflight_q + fifo_count) < CW'(FIFO_DEPTH);
    assign accept     = req_valid && req_ready;
    assign retire     = vld_q[LATENCY-1];
    assign inflight_d = inflight_q + CW'(accept) - CW'(retire);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q      <= '0;
            inflight_q <= '0;
        end else begin
            vld_q      <= {vld_q[LATENCY-2:0], accept};
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        word_q[0] <= decode_op(req_op, req_asrc, req_bsrc, req_osel);
        tag_q[0]  <= req_tag;
        for (int k = 1; k < LATENCY; k++) begin
            word_q[k] <= word_q[k-1];
            tag_q[k]  <= tag_q[k-1];
        end
    end

    // Each control comes from the stage that the matching ALU stage consumes; empty stages drive 0.
    assign {alu_bmux1, alu_bmux0}   = vld_q[TAP_SEL]  ? word_q[TAP_SEL].bmux  : 2'b00;
    assign alu_amux                 = vld_q[TAP_SEL]  ? word_q[TAP_SEL].amux  : 1'b0;
    assign alu_sub                  = vld_q[TAP_INV]  ? word_q[TAP_INV].sub   : 1'b0;
    assign alu_stl                  = vld_q[TAP_INV]  ? word_q[TAP_INV].stl   : 1'b0;
    assign alu_cin                  = vld_q[TAP_ADD]  ? word_q[TAP_ADD].cin   : 1'b0;
    assign {alu_ctrl1, alu_ctrl0}   = vld_q[TAP_MUX]  ? word_q[TAP_MUX].ctrl  : 2'b00;
    assign {alu_mux3_1, alu_mux3_0} = vld_q[TAP_OSEL] ? word_q[TAP_OSEL].osel : 2'b00;

`ifdef ALU_SEQ_ZFLAG_EN
    // Zero flag captured at TAP_ZERO and carried alongside the word to the last stage.
    logic zpipe_q [ZN];

    always_ff @(posedge clk) begin
        zpipe_q[0] <= alu_zero;
        for (int k = 1; k < ZN; k++) zpipe_q[k] <= zpipe_q[k-1];
    end

    assign push_data = {word_q[LATENCY-1].illegal, zpipe_q[ZN-1], tag_q[LATENCY-1], alu_out};
    assign rsp_zero  = rd_data[DATA_W+TAG_W];
`else
    logic unused_zero;

    assign unused_zero = alu_zero;
    assign push_data   = {word_q[LATENCY-1].illegal, tag_q[LATENCY-1], alu_out};
    assign rsp_zero    = 1'b0;
`endif

    alu_seq_rsp_fifo #(
        .W     (PW),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (retire),
        .push_data_i (push_data),
        .pop_i       (rsp_ready),
        .rd_valid_o  (rsp_valid),
        .rd_data_o   (rd_data),
        .count_o     (fifo_count)
    );

    assign rsp_illegal = rd_data[PW-1];
    assign rsp_tag     = rd_data[DATA_W +: TAG_W];
    assign rsp_data    = rd_data[DATA_W-1:0];
    assign busy        = (inflight_q != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Scoreboard bench for alu_issue_sequencer: a cycle-indexed reference of control taps and responses.
module tb_alu_issue_sequencer;

    localparam int LAT = 16, DEPTH = 4;
    localparam int T_SEL = 1, T_INV = 3, T_ADD = 4, T_MUX = 12, T_OSEL = 15, T_ZERO = 10;
    localparam int NCYC = 4096;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_bsrc = 1'b0, rsp_ready = 1'b0;
    logic [2:0]  req_op = '0;
    logic [1:0]  req_asrc = '0, req_osel = '0;
    logic [3:0]  req_tag = '0;
    logic        alu_ctrl0, alu_ctrl1, alu_sub, alu_stl, alu_cin;
    logic        alu_bmux0, alu_bmux1, alu_amux, alu_mux3_0, alu_mux3_1;
    logic [15:0] alu_out, rsp_data;
    logic        alu_zero, rsp_valid, rsp_zero, rsp_illegal, busy;
    logic [3:0]  rsp_tag;

    typedef struct {
        int          t;
        logic [15:0] data;
        logic        zero;
        logic [3:0]  tag;
        logic        ill;
    } exp_t;

    exp_t       sb[$];
    logic [9:0] exp_ctl [NCYC];
    int         cyc = 0, checks = 0, errors = 0, naccept = 0;

    alu_issue_sequencer dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_asrc(req_asrc), .req_bsrc(req_bsrc), .req_osel(req_osel), .req_tag(req_tag),
        .alu_ctrl0(alu_ctrl0), .alu_ctrl1(alu_ctrl1), .alu_sub(alu_sub), .alu_stl(alu_stl),
        .alu_cin(alu_cin), .alu_bmux0(alu_bmux0), .alu_bmux1(alu_bmux1), .alu_amux(alu_amux),
        .alu_mux3_0(alu_mux3_0), .alu_mux3_1(alu_mux3_1), .alu_out(alu_out), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
        .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        #1;
        cyc++;
    end

    // The ALU model presents a value that is a pure function of the cycle number.
    function automatic logic [15:0] aluv(input int c);
        int x;
        x = c * 40503 + 12345;
        return 16'(x ^ (x >>> 7));
    endfunction

    function automatic logic zf(input int c);
        return ((c * 13) % 4) == 0;
    endfunction

    assign alu_out  = aluv(cyc);
    assign alu_zero = zf(cyc);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_accept(input int t, input logic [2:0] op, input logic [1:0] a,
                                input logic b, input logic [1:0] o, input logic [3:0] tag);
        logic [1:0] ctrl;
        logic       sub, stl, cin;
        exp_t       e;
        {ctrl, sub, stl, cin} = 5'b00000;
        case (op)
            3'd1: ctrl = 2'b01;
            3'd2: ctrl = 2'b10;
            3'd3: {ctrl, sub, stl, cin} = 5'b10101;
            3'd4: {ctrl, sub, stl, cin} = 5'b11111;
            default: ;
        endcase
        exp_ctl[t+1+T_MUX][9:8]  = ctrl;
        exp_ctl[t+1+T_INV][7:6]  = {sub, stl};
        exp_ctl[t+1+T_ADD][5]    = cin;
        exp_ctl[t+1+T_SEL][4:2]  = {a, b};
        exp_ctl[t+1+T_OSEL][1:0] = o;
        e.t    = t;
        e.data = aluv(t + LAT);
`ifdef ALU_SEQ_ZFLAG_EN
        e.zero = zf(t + 1 + T_ZERO);
`else
        e.zero = 1'b0;
`endif
        e.tag  = tag;
        e.ill  = (op > 3'd4);
        sb.push_back(e);
        naccept++;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [1:0] a, input logic b,
                         input logic [1:0] o, input logic [3:0] tag, input logic rr);
        logic acc;
        int   t;
        @(negedge clk);
        req_valid = v; req_op = op; req_asrc = a; req_bsrc = b; req_osel = o; req_tag = tag;
        rsp_ready = rr;
        acc = v && req_ready;
        t   = cyc;
        @(posedge clk);
        if (acc) model_accept(t, op, a, b, o, tag);
    endtask

    task automatic idle(input int n, input logic rr);
        repeat (n) drive(1'b0, 3'd0, 2'd0, 1'b0, 2'd0, 4'd0, rr);
    endtask

    task automatic rand_op(input logic rr);
        drive(1'b1, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), rr);
    endtask

    task automatic reset_pulse(input int hold);
        @(negedge clk);
        req_valid = 1'b0;
        #3 rst = 1'b1;
        sb.delete();
        for (int i = cyc; i < cyc + LAT + 4 && i < NCYC; i++) exp_ctl[i] = '0;
        repeat (hold) @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_rsp_zero", rsp_zero, 0);
        chk("rst_rsp_illegal", rsp_illegal, 0);
        chk("rst_alu_ctl", {alu_ctrl1, alu_ctrl0, alu_sub, alu_stl, alu_cin,
                            alu_bmux1, alu_bmux0, alu_amux, alu_mux3_1, alu_mux3_0}, 0);
    endtask

    // Monitor: compares taps, credits and the response head every cycle, away from the clock edge.
    initial begin
        logic [9:0] ctl;
        logic       expv;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && cyc < NCYC) begin
                ctl = {alu_ctrl1, alu_ctrl0, alu_sub, alu_stl, alu_cin,
                       alu_bmux1, alu_bmux0, alu_amux, alu_mux3_1, alu_mux3_0};
                chk("alu_ctl", ctl, exp_ctl[cyc]);
                chk("req_ready", req_ready, sb.size() < DEPTH);
                chk("busy", busy, sb.size() != 0);
                expv = (sb.size() > 0) && (cyc >= sb[0].t + LAT + 1);
                chk("rsp_valid", rsp_valid, expv);
                if (rsp_valid && sb.size() > 0) begin
                    chk("rsp_data", rsp_data, sb[0].data);
                    chk("rsp_tag", rsp_tag, sb[0].tag);
                    chk("rsp_zero", rsp_zero, sb[0].zero);
                    chk("rsp_illegal", rsp_illegal, sb[0].ill);
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int base, hi;
        for (int i = 0; i < NCYC; i++) exp_ctl[i] = '0;
        reset_pulse(3);

        // Single ADD, then SUB/SLT back to back.
        drive(1'b1, 3'd2, 2'd1, 1'b1, 2'd2, 4'd5, 1'b1);
        idle(25, 1'b1);
        drive(1'b1, 3'd3, 2'd3, 1'b0, 2'd1, 4'd9, 1'b1);
        drive(1'b1, 3'd4, 2'd2, 1'b1, 2'd3, 4'd10, 1'b1);
        idle(25, 1'b1);

        // Credit limit with a stalled consumer, then one pop frees exactly one slot.
        base = naccept;
        repeat (30) drive(1'b1, 3'd1, 2'd0, 1'b0, 2'd0, 4'd3, 1'b0);
        chk("credit_stall_accepts", naccept - base, 4);
        drive(1'b1, 3'd6, 2'd0, 1'b0, 2'd0, 4'd4, 1'b1);
        repeat (3) drive(1'b1, 3'd6, 2'd1, 1'b1, 2'd0, 4'd4, 1'b0);
        chk("credit_one_pop_accepts", naccept - base, 5);
        idle(30, 1'b1);

        // Random traffic with alternating back-pressure intensity.
        hi = 1;
        for (int i = 0; i < 1200; i++) begin
            if (i % 50 == 0) hi = $urandom_range(0, 1);
            if ($urandom_range(0, 9) < 7) rand_op(($urandom_range(0, 9) < (hi ? 9 : 2)));
            else idle(1, ($urandom_range(0, 9) < (hi ? 9 : 2)));
        end
        idle(40, 1'b1);

        // Reset with three ops in flight: none may come back.
        repeat (3) rand_op(1'b1);
        idle(5, 1'b1);
        reset_pulse(2);
        idle(30, 1'b1);

        for (int i = 0; i < 100 && sb.size() != 0; i++) idle(1, 1'b1);
        chk("drain_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
